// File: rtl/tcam_mp_pkg.sv
// Shared definitions for the multi-port ternary CAM.
//   tcam_aw     : address width for a given entry count (minimum 1 bit)
//   match_res_t : per-channel match result {hit, multi, addr}; addr is sized
//                 for the largest supported table (256 entries) and narrowed
//                 by the user.
package tcam_mp_pkg;

  localparam int ADDR_MAX_W = 8;

  function automatic int tcam_aw(input int items);
    return (items > 1) ? $clog2(items) : 1;
  endfunction

  typedef struct packed {
    logic                  hit;
    logic                  multi;
    logic [ADDR_MAX_W-1:0] addr;
  } match_res_t;

endpackage

// File: rtl/tcam_mp_prio_enc.sv
// Combinational priority encoder for one match channel.
//   vec   : per-entry hit vector (ITEMS bits)
//   idx   : lowest set index, 0 when vec is empty
//   any   : at least one bit set
//   multi : two or more bits set
module tcam_mp_prio_enc
  import tcam_mp_pkg::*;
#(
  parameter int ITEMS = 16,
  localparam int AW = tcam_aw(ITEMS)
) (
  input  logic [ITEMS-1:0] vec,
  output logic [AW-1:0]    idx,
  output logic             any,
  output logic             multi
);

  always_comb begin
    idx   = '0;
    any   = 1'b0;
    multi = 1'b0;
    // Scan downwards so the last assignment wins with the lowest index.
    for (int i = ITEMS - 1; i >= 0; i--) begin
      if (vec[i]) idx = AW'(i);
    end
    // A second hit after any earlier one means popcount >= 2.
    for (int i = 0; i < ITEMS; i++) begin
      multi = multi | (any & vec[i]);
      any   = any | vec[i];
    end
  end

endmodule

// File: rtl/tcam_mp.sv
// Register-based ternary CAM with per-entry valid bits, MATCH_PORTS
// independent lookup channels, entry erase and flash clear.
//   CLK/RST               : clock, asynchronous active-high reset
//   WRITE_*               : install (WRITE_VALID=1) or erase (0) one entry
//   CLEAR_EN              : invalidate all entries (a same-cycle write wins for its address)
//   READ_*                : read back data/mask/valid, latency 1+OUTPUT_READ_REGS
//   MATCH_DATA/MATCH_EN   : per-channel keys and requests
//   MATCH_OUT_*           : per-channel hit/multi/lowest-address, latency 2
//   *_RDY                 : high whenever out of reset; no back-pressure
module tcam_mp
  import tcam_mp_pkg::*;
#(
  parameter int DATA_WIDTH         = 16,
  parameter int ITEMS              = 16,
  parameter int MATCH_PORTS        = 2,
  parameter bit WRITE_BEFORE_MATCH = 1'b0,
  parameter bit OUTPUT_READ_REGS   = 1'b1,
  localparam int AW = tcam_aw(ITEMS)
) (
  input  logic                            CLK,
  input  logic                            RST,
  input  logic [AW-1:0]                   WRITE_ADDR,
  input  logic [DATA_WIDTH-1:0]           WRITE_DATA,
  input  logic [DATA_WIDTH-1:0]           WRITE_MASK,
  input  logic                            WRITE_VALID,
  input  logic                            WRITE_EN,
  output logic                            WRITE_RDY,
  input  logic                            CLEAR_EN,
  input  logic [AW-1:0]                   READ_ADDR,
  input  logic                            READ_EN,
  output logic                            READ_RDY,
  output logic [DATA_WIDTH-1:0]           READ_DATA,
  output logic [DATA_WIDTH-1:0]           READ_MASK,
  output logic                            READ_VALID,
  output logic                            READ_DATA_VLD,
  input  logic [MATCH_PORTS*DATA_WIDTH-1:0] MATCH_DATA,
  input  logic [MATCH_PORTS-1:0]          MATCH_EN,
  output logic                            MATCH_RDY,
  output logic [MATCH_PORTS-1:0]          MATCH_OUT_HIT,
  output logic [MATCH_PORTS-1:0]          MATCH_OUT_MULTI,
  output logic [MATCH_PORTS*AW-1:0]       MATCH_OUT_ADDR,
  output logic [MATCH_PORTS-1:0]          MATCH_OUT_VLD
);

  logic rdy;
  assign rdy       = ~RST;
  assign WRITE_RDY = rdy;
  assign READ_RDY  = rdy;
  assign MATCH_RDY = rdy;

  logic [DATA_WIDTH-1:0] data_q [ITEMS];
  logic [DATA_WIDTH-1:0] mask_q [ITEMS];
  logic [ITEMS-1:0]      valid_q, valid_nxt;
  logic                  wr, wr_set;

  assign wr     = WRITE_EN & rdy;
  assign wr_set = wr & WRITE_VALID;

  always_comb begin
    valid_nxt = (CLEAR_EN && rdy) ? '0 : valid_q;
    if (wr) valid_nxt[WRITE_ADDR] = WRITE_VALID;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) valid_q <= '0;
    else     valid_q <= valid_nxt;
  end

  // Erase leaves data/mask untouched so they stay readable.
  always_ff @(posedge CLK) begin
    if (wr_set) begin
      data_q[WRITE_ADDR] <= WRITE_DATA;
      mask_q[WRITE_ADDR] <= WRITE_MASK;
    end
  end

  // Table as seen by matches this cycle: either the registered state or the
  // state being written now.
  logic [DATA_WIDTH-1:0] view_data [ITEMS];
  logic [DATA_WIDTH-1:0] view_mask [ITEMS];
  logic [ITEMS-1:0]      view_valid;

  always_comb begin
    view_valid = WRITE_BEFORE_MATCH ? valid_nxt : valid_q;
    for (int i = 0; i < ITEMS; i++) begin
      view_data[i] = data_q[i];
      view_mask[i] = mask_q[i];
      if (WRITE_BEFORE_MATCH && wr_set && (WRITE_ADDR == AW'(i))) begin
        view_data[i] = WRITE_DATA;
        view_mask[i] = WRITE_MASK;
      end
    end
  end

  logic [ITEMS-1:0] hit_vec [MATCH_PORTS];

  always_comb begin
    for (int c = 0; c < MATCH_PORTS; c++) begin
      hit_vec[c] = '0;
      for (int i = 0; i < ITEMS; i++) begin
        hit_vec[c][i] = view_valid[i] &&
          (((MATCH_DATA[c*DATA_WIDTH +: DATA_WIDTH] ^ view_data[i]) & view_mask[i]) == '0);
      end
    end
  end

  // ---- stage 1: per-channel hit vectors ----
  logic [ITEMS-1:0]       hit_p1 [MATCH_PORTS];
  logic [MATCH_PORTS-1:0] vld_p1;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) vld_p1 <= '0;
    else     vld_p1 <= MATCH_EN;
  end

  always_ff @(posedge CLK) begin
    for (int c = 0; c < MATCH_PORTS; c++) hit_p1[c] <= hit_vec[c];
  end

  logic [AW-1:0]          enc_idx [MATCH_PORTS];
  logic [MATCH_PORTS-1:0] enc_any, enc_multi;

  for (genvar c = 0; c < MATCH_PORTS; c++) begin : g_enc
    tcam_mp_prio_enc #(.ITEMS(ITEMS)) u_enc (
      .vec   (hit_p1[c]),
      .idx   (enc_idx[c]),
      .any   (enc_any[c]),
      .multi (enc_multi[c])
    );
  end

  // ---- stage 2: encoded results ----
  match_res_t             res_p2 [MATCH_PORTS];
  logic [MATCH_PORTS-1:0] vld_p2;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      vld_p2 <= '0;
      for (int c = 0; c < MATCH_PORTS; c++) res_p2[c] <= '0;
    end else begin
      vld_p2 <= vld_p1;
      for (int c = 0; c < MATCH_PORTS; c++) begin
        if (vld_p1[c]) begin
          res_p2[c].hit   <= enc_any[c];
          res_p2[c].multi <= enc_multi[c];
          res_p2[c].addr  <= ADDR_MAX_W'(enc_idx[c]);
        end
      end
    end
  end

  logic unused_addr_bits;

  always_comb begin
    unused_addr_bits = 1'b0;
    for (int c = 0; c < MATCH_PORTS; c++) begin
      MATCH_OUT_HIT[c]             = res_p2[c].hit;
      MATCH_OUT_MULTI[c]           = res_p2[c].multi;
      MATCH_OUT_ADDR[c*AW +: AW]   = res_p2[c].addr[AW-1:0];
      unused_addr_bits             = unused_addr_bits ^ (^res_p2[c].addr);
    end
  end
  assign MATCH_OUT_VLD = vld_p2;

  // ---- read stage 1: registered table contents ----
  logic [DATA_WIDTH-1:0] rd_data_p1, rd_mask_p1;
  logic                  rd_valid_p1, rd_vld_p1;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rd_vld_p1   <= 1'b0;
      rd_data_p1  <= '0;
      rd_mask_p1  <= '0;
      rd_valid_p1 <= 1'b0;
    end else begin
      rd_vld_p1 <= READ_EN;
      if (READ_EN) begin
        rd_data_p1  <= data_q[READ_ADDR];
        rd_mask_p1  <= mask_q[READ_ADDR];
        rd_valid_p1 <= valid_q[READ_ADDR];
      end
    end
  end

  if (OUTPUT_READ_REGS) begin : g_rd_reg
    // ---- read stage 2: optional output register ----
    logic [DATA_WIDTH-1:0] rd_data_p2, rd_mask_p2;
    logic                  rd_valid_p2, rd_vld_p2;

    always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
        rd_vld_p2   <= 1'b0;
        rd_data_p2  <= '0;
        rd_mask_p2  <= '0;
        rd_valid_p2 <= 1'b0;
      end else begin
        rd_vld_p2 <= rd_vld_p1;
        if (rd_vld_p1) begin
          rd_data_p2  <= rd_data_p1;
          rd_mask_p2  <= rd_mask_p1;
          rd_valid_p2 <= rd_valid_p1;
        end
      end
    end

    assign READ_DATA     = rd_data_p2;
    assign READ_MASK     = rd_mask_p2;
    assign READ_VALID    = rd_valid_p2;
    assign READ_DATA_VLD = rd_vld_p2;
  end else begin : g_rd_direct
    assign READ_DATA     = rd_data_p1;
    assign READ_MASK     = rd_mask_p1;
    assign READ_VALID    = rd_valid_p1;
    assign READ_DATA_VLD = rd_vld_p1;
  end

endmodule

// File: tb/tb_tcam_mp.sv
// Directed bench for tcam_mp: two instances share all stimulus, one with
// WRITE_BEFORE_MATCH=0 (index 0) and one with WRITE_BEFORE_MATCH=1 (index 1).
module tb_tcam_mp;
  localparam int DW = 8;
  localparam int N  = 8;
  localparam int MP = 2;
  localparam int AW = 3;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic [AW-1:0]    WRITE_ADDR = '0;
  logic [DW-1:0]    WRITE_DATA = '0;
  logic [DW-1:0]    WRITE_MASK = '0;
  logic             WRITE_VALID = 1'b0;
  logic             WRITE_EN = 1'b0;
  logic             CLEAR_EN = 1'b0;
  logic [AW-1:0]    READ_ADDR = '0;
  logic             READ_EN = 1'b0;
  logic [MP*DW-1:0] MATCH_DATA = '0;
  logic [MP-1:0]    MATCH_EN = '0;

  logic             wr_rdy [2];
  logic             rd_rdy [2];
  logic             m_rdy  [2];
  logic [DW-1:0]    rd_data [2];
  logic [DW-1:0]    rd_mask [2];
  logic             rd_valid [2];
  logic             rd_vld [2];
  logic [MP-1:0]    m_hit [2];
  logic [MP-1:0]    m_multi [2];
  logic [MP*AW-1:0] m_addr [2];
  logic [MP-1:0]    m_vld [2];

  int checks = 0;
  int errors = 0;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    tcam_mp #(
      .DATA_WIDTH(DW), .ITEMS(N), .MATCH_PORTS(MP),
      .WRITE_BEFORE_MATCH(g == 1), .OUTPUT_READ_REGS(1'b1)
    ) dut (
      .CLK(CLK), .RST(RST),
      .WRITE_ADDR(WRITE_ADDR), .WRITE_DATA(WRITE_DATA), .WRITE_MASK(WRITE_MASK),
      .WRITE_VALID(WRITE_VALID), .WRITE_EN(WRITE_EN), .WRITE_RDY(wr_rdy[g]),
      .CLEAR_EN(CLEAR_EN),
      .READ_ADDR(READ_ADDR), .READ_EN(READ_EN), .READ_RDY(rd_rdy[g]),
      .READ_DATA(rd_data[g]), .READ_MASK(rd_mask[g]), .READ_VALID(rd_valid[g]),
      .READ_DATA_VLD(rd_vld[g]),
      .MATCH_DATA(MATCH_DATA), .MATCH_EN(MATCH_EN), .MATCH_RDY(m_rdy[g]),
      .MATCH_OUT_HIT(m_hit[g]), .MATCH_OUT_MULTI(m_multi[g]),
      .MATCH_OUT_ADDR(m_addr[g]), .MATCH_OUT_VLD(m_vld[g])
    );
  end

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d,
                    input logic [DW-1:0] m, input logic v);
    WRITE_ADDR = a; WRITE_DATA = d; WRITE_MASK = m; WRITE_VALID = v; WRITE_EN = 1'b1;
    tick();
    WRITE_EN = 1'b0;
  endtask

  // Issue one match on both channels; checks nothing is valid one cycle
  // later, leaves the result on the outputs two cycles after acceptance.
  task automatic match(input string tag, input logic [DW-1:0] k0, input logic [DW-1:0] k1);
    MATCH_DATA = {k1, k0}; MATCH_EN = 2'b11;
    tick();
    MATCH_EN = 2'b00;
    chk({tag, ".vld_t1"}, 32'(m_vld[0]), 32'h0);
    tick();
  endtask

  task automatic chk_match(input int d, input string tag, input logic [MP-1:0] vld,
                           input logic [MP-1:0] hit, input logic [MP-1:0] multi,
                           input logic [MP*AW-1:0] addr);
    chk({tag, ".vld"},   32'(m_vld[d]),   32'(vld));
    chk({tag, ".hit"},   32'(m_hit[d]),   32'(hit));
    chk({tag, ".multi"}, 32'(m_multi[d]), 32'(multi));
    chk({tag, ".addr"},  32'(m_addr[d]),  32'(addr));
  endtask

  task automatic rd(input string tag, input logic [AW-1:0] a);
    READ_ADDR = a; READ_EN = 1'b1;
    tick();
    READ_EN = 1'b0;
    chk({tag, ".vld_t1"}, 32'(rd_vld[0]), 32'h0);
    tick();
    chk({tag, ".vld"}, 32'(rd_vld[0]), 32'h1);
  endtask

  initial begin
    // Reset state
    tick(); tick();
    chk("rst.wr_rdy", 32'(wr_rdy[0]), 32'h0);
    chk("rst.rd_rdy", 32'(rd_rdy[0]), 32'h0);
    chk("rst.m_rdy",  32'(m_rdy[1]),  32'h0);
    chk_match(0, "rst", 2'b00, 2'b00, 2'b00, 6'o00);
    chk("rst.rd_vld",   32'(rd_vld[0]),   32'h0);
    chk("rst.rd_data",  32'(rd_data[0]),  32'h0);
    chk("rst.rd_valid", 32'(rd_valid[0]), 32'h0);
    RST = 1'b0;
    #1;
    chk("rel.m_rdy",  32'(m_rdy[0]),  32'h1);
    chk("rel.wr_rdy", 32'(wr_rdy[1]), 32'h1);

    // Empty table misses everything
    match("empty", 8'h00, 8'hFF);
    chk_match(0, "empty", 2'b11, 2'b00, 2'b00, 6'o00);

    // Priority and multi-hit
    wr(3'd3, 8'hA0, 8'hF0, 1'b1);
    wr(3'd5, 8'hA5, 8'hFF, 1'b1);
    match("prio", 8'hA5, 8'hA1);
    chk_match(0, "prio", 2'b11, 2'b11, 2'b01, 6'o33);

    // Erase e3 with different data on the bus: contents must be kept
    wr(3'd3, 8'h00, 8'h00, 1'b0);
    match("erase", 8'hA5, 8'hA1);
    chk_match(0, "erase", 2'b11, 2'b01, 2'b00, 6'o05);
    rd("rd_e3", 3'd3);
    chk("rd_e3.data",  32'(rd_data[0]),  32'hA0);
    chk("rd_e3.mask",  32'(rd_mask[0]),  32'hF0);
    chk("rd_e3.valid", 32'(rd_valid[0]), 32'h0);

    // Write/match collision, then a back-to-back channel-0-only match
    WRITE_ADDR = 3'd1; WRITE_DATA = 8'h11; WRITE_MASK = 8'hFF; WRITE_VALID = 1'b1;
    WRITE_EN = 1'b1;
    MATCH_DATA = {8'h11, 8'h11}; MATCH_EN = 2'b11;
    tick();
    WRITE_EN = 1'b0;
    MATCH_EN = 2'b01;
    tick();
    MATCH_EN = 2'b00;
    chk_match(0, "coll_wbm0", 2'b11, 2'b00, 2'b00, 6'o00);
    chk_match(1, "coll_wbm1", 2'b11, 2'b11, 2'b00, 6'o11);
    tick();
    chk_match(0, "coll_next", 2'b01, 2'b01, 2'b00, 6'o01);

    // Clear together with a write to e6
    WRITE_ADDR = 3'd6; WRITE_DATA = 8'h66; WRITE_MASK = 8'hFF; WRITE_VALID = 1'b1;
    WRITE_EN = 1'b1; CLEAR_EN = 1'b1;
    tick();
    WRITE_EN = 1'b0; CLEAR_EN = 1'b0;
    match("clr_miss", 8'h11, 8'hA5);
    chk_match(0, "clr_miss", 2'b11, 2'b00, 2'b00, 6'o00);
    match("clr_hit", 8'h66, 8'h11);
    chk_match(0, "clr_hit", 2'b11, 2'b01, 2'b00, 6'o06);

    // Read in the same cycle as a write to that address returns old contents
    WRITE_ADDR = 3'd6; WRITE_DATA = 8'h77; WRITE_MASK = 8'h0F; WRITE_VALID = 1'b1;
    WRITE_EN = 1'b1;
    READ_ADDR = 3'd6; READ_EN = 1'b1;
    tick();
    WRITE_EN = 1'b0; READ_EN = 1'b0;
    tick();
    chk("rdw.vld",   32'(rd_vld[0]),   32'h1);
    chk("rdw.data",  32'(rd_data[0]),  32'h66);
    chk("rdw.mask",  32'(rd_mask[0]),  32'hFF);
    rd("rd_e6", 3'd6);
    chk("rd_e6.data", 32'(rd_data[0]), 32'h77);
    chk("rd_e6.mask", 32'(rd_mask[0]), 32'h0F);
    // Mask 0x0F on 0x77: key 0x57 hits, 0x76 misses
    match("mask", 8'h57, 8'h76);
    chk_match(0, "mask", 2'b11, 2'b01, 2'b00, 6'o06);

    // Reset mid-stream
    MATCH_DATA = {8'h57, 8'h57}; MATCH_EN = 2'b11;
    tick(); tick();
    chk("mid.vld_run", 32'(m_vld[0]), 32'h3);
    tick();
    MATCH_EN = 2'b00;
    RST = 1'b1;
    #1;
    chk("mid.vld_rst", 32'(m_vld[0]), 32'h0);
    chk("mid.hit_rst", 32'(m_hit[1]), 32'h0);
    tick();
    RST = 1'b0;
    tick();
    chk("mid.vld_rel1", 32'(m_vld[0]), 32'h0);
    chk("mid.vld_rel1b", 32'(m_vld[1]), 32'h0);
    tick();
    chk("mid.vld_rel2", 32'(m_vld[0]), 32'h0);
    for (int i = 0; i < N; i++) begin
      rd("mid.rd", 3'(i));
      chk("mid.valid", 32'(rd_valid[0]), 32'h0);
    end
    match("mid.miss", 8'h57, 8'h11);
    chk_match(0, "mid.miss", 2'b11, 2'b00, 2'b00, 6'o00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tcam_mp.md
# tcam_mp

Register-based ternary CAM with per-entry valid bits, several independent match channels, entry erase and flash clear. Every channel produces a priority-encoded hit address and a multi-hit flag. It is the parametrised successor of the single-port TCAM2 in the memory component library. It targets small tables (ITEMS ≤ 256) in packet classifiers where every lane of a multi-lane bus needs a lookup in each cycle.

## Interface
- DATA_WIDTH, 16: key, data and mask width.
- ITEMS, 16: number of entries, power of two ≥ 2; AW = log2(ITEMS).
- MATCH_PORTS, 2: number of independent match channels, ≥ 1.
- WRITE_BEFORE_MATCH, 0: 1 means a match issued in the write cycle sees the new entry.
- OUTPUT_READ_REGS, 1: adds one register stage on the read output.

Ports:
- CLK  in  1  clock
- RST  in  1  reset, asynchronous, active-high
- WRITE_ADDR  in  AW  entry index
- WRITE_DATA  in  DATA_WIDTH  stored data
- WRITE_MASK  in  DATA_WIDTH  care mask (1 = bit compared)
- WRITE_VALID  in  1  1 = install entry, 0 = erase entry
- WRITE_EN  in  1  write request
- WRITE_RDY  out  1  write accepted
- CLEAR_EN  in  1  invalidate all entries
- READ_ADDR  in  AW  entry index
- READ_EN  in  1  read request
- READ_RDY  out  1  read accepted
- READ_DATA / READ_MASK  out  DATA_WIDTH each  stored contents
- READ_VALID  out  1  entry valid bit
- READ_DATA_VLD  out  1  read output strobe
- MATCH_DATA  in  MATCH_PORTS*DATA_WIDTH  keys; channel c at bits [c*DATA_WIDTH +: DATA_WIDTH]
- MATCH_EN  in  MATCH_PORTS  per-channel request
- MATCH_RDY  out  1  all channels accepted
- MATCH_OUT_HIT  out  MATCH_PORTS  at least one entry hit
- MATCH_OUT_MULTI  out  MATCH_PORTS  more than one entry hit
- MATCH_OUT_ADDR  out  MATCH_PORTS*AW  lowest hitting index
- MATCH_OUT_VLD  out  MATCH_PORTS  per-channel result strobe

## Operation
- Entry i hits key k when VALID[i]=1 and ((k xor DATA[i]) and MASK[i]) = 0. An all-zero mask on a valid entry hits every key.
- A write with WRITE_VALID=1 stores DATA, MASK and sets VALID. A write with WRITE_VALID=0 clears VALID only; DATA and MASK are left unchanged.
- CLEAR_EN clears every VALID bit in one cycle. If CLEAR_EN and a write arrive in the same cycle, the write takes priority for its own address; all other entries are cleared.
- Channels operate independently, and each compares against all ITEMS entries in parallel. The channel with MATCH_EN=0 in a cycle produces MATCH_OUT_VLD=0 for that slot.
- Result per channel: HIT = OR of the hit vector. ADDR = lowest set index, or 0 when no entry hits. MULTI = popcount ≥ 2.
- Effect of a write, erase or clear on a match issued in the same cycle:
  - WRITE_BEFORE_MATCH=0: the match sees the pre-update table.
  - WRITE_BEFORE_MATCH=1: the match sees the post-update table (combinational bypass).
  - A match issued one or more cycles after the update always sees the update.
- READ returns the registered contents at READ_ADDR. A read issued in the same cycle as a write to that address returns the old contents.
- RDY outputs are 0 while RST=1 and 1 otherwise. The block never back-pressures.

## Timing
- Reset values: VALID[*]=0, DATA/MASK unspecified. All *_VLD, HIT, MULTI, ADDR, READ_* outputs = 0. All RDY = 0.
- Match latency is 2 cycles. A request accepted at cycle t produces its result at t+2.
  - Stage 1 registers the per-channel hit vector.
  - Stage 2 registers the encoder output.
- Match is fully pipelined at 1 request per cycle per channel.
- Read latency is 1 + OUTPUT_READ_REGS cycles, pipelined.
- Reset asserted mid-pipeline discards all in-flight results. No *_VLD may be asserted in the cycle after RST is released.

## Structure
- Package tcam_mp_pkg holds a clog2-based AW helper function and the typedef of the per-channel result struct {hit, multi, addr}.
- Sub-module tcam_mp_prio_enc takes an ITEMS-wide vector and outputs the lowest index, any-hit and multi-hit flags; it is purely combinational. There is one instance per channel.
- Storage is implemented as flops. There is no RAM inference.

## Test plan
Common setup: DATA_WIDTH=8, ITEMS=8, MATCH_PORTS=2, WRITE_BEFORE_MATCH=0.
- Reset then match: ch0 key 0x00, ch1 key 0xFF -> at t+2 both VLD=1, HIT=0, MULTI=0, ADDR=0.
- Priority and multi-hit: write e3=(0xA0, mask 0xF0), e5=(0xA5, mask 0xFF); match 0xA5 -> HIT=1, ADDR=3, MULTI=1. Match 0xA1 -> ADDR=3, MULTI=0.
- Erase: erase e3, then match 0xA5 -> ADDR=5, MULTI=0. Read e3 -> DATA=0xA0, MASK=0xF0, VALID=0.
- Write/match collision: write e1=(0x11, 0xFF) and match 0x11 in the same cycle.
  - WRITE_BEFORE_MATCH=0 -> HIT=0; the next-cycle match -> HIT=1, ADDR=1.
  - WRITE_BEFORE_MATCH=1 -> the same-cycle match gives HIT=1.
- Clear with write: with e1 and e5 valid, CLEAR_EN and write e6=(0x66, 0xFF) in the same cycle -> matches 0x11 and 0xA5 miss; 0x66 hits ADDR=6.
- Reset mid-stream: issue matches on 3 consecutive cycles, assert RST for 1 cycle -> no VLD after release; all entries invalid.
